// File: rtl/ling_seq_adder.sv
// Nibble-serial WIDTH-bit adder built around one shared 4-bit Ling carry slice.
// Defining ADDSUB_SUB_EN adds the op port and a - b support.

module ling_slice4 (
   input  logic [3:0] i_a,
   input  logic [3:0] i_b,
   input  logic       i_c,
   output logic [3:0] o_s,
   output logic       o_c
);
   logic [3:0] w_g;
   logic [3:0] w_t;
   logic [3:0] w_p;
   logic [3:0] w_h;
   logic [3:0] w_c;

   assign w_g = i_a & i_b;
   assign w_t = i_a | i_b;
   assign w_p = i_a ^ i_b;

   // Pseudo-carries H_i; the real carry is recovered as c_i = t_i & H_i.
   assign w_h[0] = w_g[0] | i_c;
   assign w_h[1] = w_g[1] | w_g[0] | (w_t[0] & i_c);
   assign w_h[2] = w_g[2] | w_g[1] | (w_t[1] & w_g[0]) | (w_t[1] & w_t[0] & i_c);
   assign w_h[3] = w_g[3] | w_g[2] | (w_t[2] & w_g[1]) | (w_t[2] & w_t[1] & w_g[0])
                 | (w_t[2] & w_t[1] & w_t[0] & i_c);

   assign w_c = w_t & w_h;
   assign o_s = w_p ^ {w_c[2:0], i_c};
   assign o_c = w_c[3];
endmodule

module ling_seq_adder #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
`ifdef ADDSUB_SUB_EN
   input  logic             op,
`endif
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf,
   output logic             busy
);
   localparam int N    = WIDTH / 4;
   localparam int IDXW = (N > 1) ? $clog2(N) : 1;
   localparam logic [IDXW-1:0] LAST_IDX = IDXW'(N - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t            r_state;
   logic [IDXW-1:0]   r_idx;
   logic              r_carry;
   logic [WIDTH-1:0]  r_a;
   logic [WIDTH-1:0]  r_b;
   logic [WIDTH-1:0]  r_sum;
   logic              r_cout;
   logic              r_ovf;
   logic              r_out_valid;
   logic              r_busy;

   logic [3:0]        w_slice_sum;
   logic              w_slice_cout;

   ling_slice4 u_slice (
      .i_a (r_a[{r_idx, 2'b00} +: 4]),
      .i_b (r_b[{r_idx, 2'b00} +: 4]),
      .i_c (r_carry),
      .o_s (w_slice_sum),
      .o_c (w_slice_cout)
   );

   assign in_ready  = (r_state == S_IDLE);
   assign out_valid = r_out_valid;
   assign sum       = r_sum;
   assign cout      = r_cout;
   assign ovf       = r_ovf;
   assign busy      = r_busy;

   // Sequencer: accept, step one nibble per edge, hold the result until taken.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_idx       <= {IDXW{1'b0}};
         r_carry     <= 1'b0;
         r_a         <= {WIDTH{1'b0}};
         r_b         <= {WIDTH{1'b0}};
         r_sum       <= {WIDTH{1'b0}};
         r_cout      <= 1'b0;
         r_ovf       <= 1'b0;
         r_out_valid <= 1'b0;
         r_busy      <= 1'b0;
      end else if (flush) begin
         r_state     <= S_IDLE;
         r_idx       <= {IDXW{1'b0}};
         r_carry     <= 1'b0;
         r_sum       <= {WIDTH{1'b0}};
         r_cout      <= 1'b0;
         r_ovf       <= 1'b0;
         r_out_valid <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (in_valid) begin
                  r_a     <= a;
`ifdef ADDSUB_SUB_EN
                  r_b     <= op ? ~b : b;
                  r_carry <= op ? 1'b1 : cin;
`else
                  r_b     <= b;
                  r_carry <= cin;
`endif
                  r_idx   <= {IDXW{1'b0}};
                  r_sum   <= {WIDTH{1'b0}};
                  r_state <= S_RUN;
                  r_busy  <= 1'b1;
               end
            end
            S_RUN: begin
               r_sum[{r_idx, 2'b00} +: 4] <= w_slice_sum;
               r_carry <= w_slice_cout;
               if (r_idx == LAST_IDX) begin
                  r_idx       <= {IDXW{1'b0}};
                  r_cout      <= w_slice_cout;
                  // Sign of the result is the top bit of the nibble being written now.
                  r_ovf       <= (r_a[WIDTH-1] == r_b[WIDTH-1]) &&
                                 (w_slice_sum[3] != r_a[WIDTH-1]);
                  r_out_valid <= 1'b1;
                  r_state     <= S_DONE;
               end else begin
                  r_idx <= r_idx + {{(IDXW-1){1'b0}}, 1'b1};
               end
            end
            S_DONE: begin
               if (out_ready) begin
                  r_out_valid <= 1'b0;
                  r_busy      <= 1'b0;
                  r_state     <= S_IDLE;
               end
            end
            default: begin
               r_state     <= S_IDLE;
               r_idx       <= {IDXW{1'b0}};
               r_out_valid <= 1'b0;
               r_busy      <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: doc/ling_seq_adder.md
# ling_seq_adder

Multi-cycle sequencer that computes a WIDTH-bit add using a single shared 4-bit Ling carry slice. It processes one nibble per clock and keeps the carry in a register between nibbles. It sits between an operand producer and a result consumer, with a valid/ready handshake on each side. It trades throughput for area against the fully unrolled 32-bit Ling adder: one operation completes every WIDTH/4 + 2 cycles.

## Interface
- WIDTH, 32, operand/result width; must be a multiple of 4 and at least 8
- N (localparam), WIDTH/4, number of nibble steps
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, asynchronous and active-low
- in_valid  in  1  operand request
- in_ready  out  1  block can accept operands
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- cin  in  1  carry-in
- op  in  1  operation select; port exists only with ADDSUB_SUB_EN
- flush  in  1  synchronous abort
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- sum  out  WIDTH  result
- cout  out  1  carry-out; with ADDSUB_SUB_EN and op=1, this is the not-borrow flag
- ovf  out  1  two's-complement overflow
- busy  out  1  high in RUN or DONE

## Operation
- States:
  - IDLE: in_ready=1.
  - RUN: nibble stepping.
  - DONE: out_valid=1, sum/cout/ovf held.
- IDLE -> RUN on in_valid && in_ready. On that edge:
  - Latch a and b into operand registers. The captured b is pre-inverted when subtracting.
  - carry_r <= cin (or 1 when subtracting).
  - idx <= 0.
  - Clear the sum register.
- RUN, each edge:
  - The slice adds a_r[4*idx+3:4*idx] + b_r[4*idx+3:4*idx] + carry_r.
  - The 4-bit result is written into sum[4*idx+3:4*idx].
  - carry_r <= slice carry-out; idx <= idx+1.
  - When idx == N-1, go to DONE on the same edge.
- DONE -> IDLE on out_ready. While out_ready=0, the outputs stay stable indefinitely.
- The slice is the team's existing 4-bit Ling slice (pseudo-carry form), instantiated once. No second adder is permitted.
- Arithmetic:
  - {cout,sum} = a + b + cin, modulo 2^(WIDTH+1).
  - ovf = (a_r[W-1] == b_r[W-1]) && (sum[W-1] != a_r[W-1]), using the post-inversion b_r.
- Inputs a, b, cin, op are sampled only on the accept edge. Later changes have no effect.
- flush: any state -> IDLE at the next edge. out_valid drops and sum/cout/ovf are cleared. flush has priority over accept and over out_ready.
- in_ready is combinational on state alone (== IDLE). It does not depend on in_valid.
- out_valid is a registered state decode.

## Timing
- Reset (rst_n low, async):
  - state=IDLE, idx=0, carry_r=0.
  - sum=0, cout=0, ovf=0, out_valid=0, busy=0.
  - in_ready=1.
  - A reset mid-RUN or mid-DONE discards the operation.
- Latency: accept on edge E0. Nibbles are computed on edges E1..EN. out_valid is high after EN, which is edge E8 for WIDTH=32.
- Minimum spacing between accepts is N+2 edges, with out_ready held high.
- in_valid asserted during RUN/DONE is not accepted, since in_ready=0. The producer must hold its operands.
- cout and ovf are updated together with the final nibble on edge EN.
- Partial sum nibbles are visible during RUN but are not valid. Consumers qualify on out_valid only.

## Configuration
- ADDSUB_SUB_EN defined:
  - The op port exists.
  - op=1 at accept: b is captured as ~b and carry_r is loaded with 1; cin is ignored. The result is a - b and cout=1 means no borrow.
  - op=0 gives a normal add.
- ADDSUB_SUB_EN undefined: the op port is absent and the block always adds. No inverter sits on the b capture path.

## Test plan
- Full carry ripple: a=0xFFFFFFFF, b=0x00000001, cin=0. Expect sum=0x00000000, cout=1, ovf=0, out_valid first high exactly 8 edges after the accept edge.
- Per-nibble carry: a=0x0F0F0F0F, b=0x01010101, cin=1. Expect sum=0x10101011, cout=0. Signed overflow: a=0x7FFFFFFF, b=1, cin=0. Expect sum=0x80000000, ovf=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE. Expect sum, cout and out_valid stable, in_ready=0, and in_valid ignored. Then out_ready=1 gives IDLE on the next edge and the next accept is one edge later.
- Flush and reset mid-op: flush at RUN idx=3 returns to IDLE with sum=0, out_valid=0. rst_n low at idx=5 gives all outputs at reset values immediately. A following op 0x12345678+0x11111111 gives 0x23456789.
- Random: 1000 random a/b/cin vectors with randomized out_ready stalls. Each result matches the 33-bit reference sum, and results are delivered exactly once and in order.
- With ADDSUB_SUB_EN: 5-7 with op=1 gives sum=0xFFFFFFFE, cout=0. 7-5 gives sum=0x00000002, cout=1. 0x80000000-1 gives ovf=1.
